mips_dump_ctrl: RTL and testbench

MIPS_DUMP_CTRL -- requirements
Module: mips_dump_ctrl

---
 rtl/mips_dbg_pkg.sv | 36 +++
 rtl/mips_dump_ctrl_if.sv | 24 ++
 rtl/dump_out_reg.sv | 47 ++++
 rtl/mips_dump_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mips_dump_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared types for the MIPS debug dump controller: FSM states, beat kinds,
// halt causes and the beat descriptor used to walk the dump sequence.
package mips_dbg_pkg;

    localparam int IDX_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_FETCH   = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        KIND_PC  = 2'd0,
        KIND_REG = 2'd1,
        KIND_MEM = 2'd2
    } kind_e;

    typedef enum logic {
        CAUSE_CAP = 1'b0,
        CAUSE_PC  = 1'b1
    } cause_e;

    typedef struct packed {
        kind_e            kind;
        logic [IDX_W-1:0] index;
    } beat_t;

    // Data memory is word-indexed in the dump but byte-addressed on the bus.
    function automatic logic [IDX_W+1:0] word_byte_addr(input logic [IDX_W-1:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/mips_dump_ctrl_if.sv
// Dump-stream handshake bundle: the controller is the master, the consumer
// of the PC/REG/MEM beats is the slave.
interface mips_dump_ctrl_if #(
    parameter int DATA_W = 32
);
    import mips_dbg_pkg::*;

    logic              out_valid;
    logic              out_ready;
    kind_e             out_kind;
    logic [IDX_W-1:0]  out_index;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid, out_kind, out_index, out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_kind, out_index, out_data,
        output out_ready
    );

endinterface

// File: rtl/dump_out_reg.sv
// Hold-until-ready output stage: loads one beat, keeps every field frozen
// while the consumer stalls, and drops valid on the accepting handshake.
module dump_out_reg
    import mips_dbg_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  beat_t             i_beat,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_fire,
    mips_dump_ctrl_if.master  dump
);

    logic              r_valid;
    kind_e             r_kind;
    logic [IDX_W-1:0]  r_index;
    logic [DATA_W-1:0] r_data;

    assign o_fire = r_valid && dump.out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_kind  <= KIND_PC;
            r_index <= '0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_kind  <= i_beat.kind;
            r_index <= i_beat.index;
            r_data  <= i_data;
        end else if (o_fire) begin
            r_valid <= 1'b0;
        end
    end

    assign dump.out_valid = r_valid;
    assign dump.out_kind  = r_kind;
    assign dump.out_index = r_index;
    assign dump.out_data  = r_data;

endmodule

// File: rtl/mips_dump_ctrl.sv
// Debug controller: runs the CPU until a PC breakpoint or cycle cap, then
// streams the halt PC, the register file and a window of data memory.
module mips_dump_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 32,
    parameter int DMEM_WORDS = 12,
    parameter int MAX_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_pc_en,
    input  logic [DATA_W-1:0] halt_pc,
    input  logic [DATA_W-1:0] cpu_pc,
    output logic              cpu_run,
    output logic [IDX_W-1:0]  rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [DATA_W-1:0] dm_raddr,
    input  logic [DATA_W-1:0] dm_rdata,
    mips_dump_ctrl_if.master  dump,
    output logic              busy,
    output logic              done,
    output logic              halt_cause,
    output logic [31:0]       run_cycles
);

    localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(DMEM_WORDS - 1);
    localparam logic [31:0]      CYC_CAP  = 32'(MAX_CYCLES);
    localparam bit               HAS_MEM  = (DMEM_WORDS > 0);

    state_e            r_state;
    logic              r_cpu_run;
    logic              r_busy;
    logic              r_done;
    cause_e            r_halt_cause;
    logic [31:0]       r_run_cycles;
    logic [DATA_W-1:0] r_pc_latch;
    beat_t             r_beat;
    logic [IDX_W-1:0]  r_rf_raddr;
    logic [DATA_W-1:0] r_dm_raddr;

    logic [31:0]       w_cycles_inc;
    logic              w_pc_hit;
    logic              w_cap_hit;
    beat_t             w_next;
    logic              w_last;
    logic [DATA_W-1:0] w_load_data;
    logic              w_load;
    logic              w_fire;

    assign w_cycles_inc = r_run_cycles + 32'd1;
    assign w_pc_hit     = halt_pc_en && (cpu_pc == halt_pc);
    assign w_cap_hit    = (w_cycles_inc >= CYC_CAP);
    assign w_load       = (r_state == ST_PRESENT) && !dump.out_valid;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_next = r_beat;
        w_last = 1'b0;
        unique case (r_beat.kind)
            KIND_PC:  w_next = '{kind: KIND_REG, index: '0};
            KIND_REG: begin
                if (r_beat.index == LAST_REG) begin
                    w_next = '{kind: KIND_MEM, index: '0};
                    w_last = !HAS_MEM;
                end else begin
                    w_next.index = r_beat.index + 1'b1;
                end
            end
            KIND_MEM: begin
                w_next.index = r_beat.index + 1'b1;
                w_last       = (r_beat.index == LAST_MEM);
            end
            default:  w_last = 1'b1;
        endcase
    end

    always_comb begin
        w_load_data = r_pc_latch;
        unique case (r_beat.kind)
            KIND_REG: w_load_data = rf_rdata;
            KIND_MEM: w_load_data = dm_rdata;
            default:  w_load_data = r_pc_latch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cpu_run    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_halt_cause <= CAUSE_CAP;
            r_run_cycles <= '0;
            r_pc_latch   <= '0;
            r_beat       <= '{kind: KIND_PC, index: '0};
            r_rf_raddr   <= '0;
            r_dm_raddr   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_RUN;
                        r_cpu_run    <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_halt_cause <= CAUSE_CAP;
                        r_run_cycles <= '0;
                    end
                end
                ST_RUN: begin
                    r_run_cycles <= w_cycles_inc;
                    // A breakpoint hit outranks the cap when both land together.
                    if (w_pc_hit || w_cap_hit) begin
                        r_state      <= ST_FETCH;
                        r_cpu_run    <= 1'b0;
                        r_halt_cause <= w_pc_hit ? CAUSE_PC : CAUSE_CAP;
                        r_pc_latch   <= cpu_pc;
                        r_beat       <= '{kind: KIND_PC, index: '0};
                    end
                end
                ST_FETCH: r_state <= ST_PRESENT;
                ST_PRESENT: begin
                    if (w_fire) begin
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_FETCH;
                            r_beat  <= w_next;
                            if (w_next.kind == KIND_REG)
                                r_rf_raddr <= w_next.index;
                            if (w_next.kind == KIND_MEM)
                                r_dm_raddr <= DATA_W'(word_byte_addr(w_next.index));
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    dump_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_beat (r_beat),
        .i_data (w_load_data),
        .o_fire (w_fire),
        .dump   (dump)
    );

    assign cpu_run    = r_cpu_run;
    assign busy       = r_busy;
    assign done       = r_done;
    assign halt_cause = r_halt_cause;
    assign run_cycles = r_run_cycles;
    assign rf_raddr   = r_rf_raddr;
    assign dm_raddr   = r_dm_raddr;

endmodule

// File: tb/tb_mips_dump_ctrl.sv
// Directed bench: instance A (32 regs, 12 mem words, cap 100) covers cap,
// breakpoint, backpressure and mid-dump reset; instance B covers the PC/cap tie.
module tb_mips_dump_ctrl;
    import mips_dbg_pkg::*;

    localparam int DW      = 32;
    localparam int A_REGS  = 32;
    localparam int A_MEM   = 12;
    localparam int A_BEATS = 1 + A_REGS + A_MEM;
    localparam int B_REGS  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          a_start = 1'b0, a_hpen = 1'b0;
    logic [DW-1:0] a_hpc = '0, a_pc;
    logic          a_cpu_run, a_busy, a_done, a_cause;
    logic [7:0]    a_rf_raddr;
    logic [DW-1:0] a_rf_rdata, a_dm_raddr, a_dm_rdata;
    logic [31:0]   a_cycles;

    logic          b_start = 1'b0, b_hpen = 1'b0;
    logic [DW-1:0] b_hpc = '0, b_pc;
    logic          b_cpu_run, b_busy, b_done, b_cause;
    logic [7:0]    b_rf_raddr;
    logic [DW-1:0] b_rf_rdata, b_dm_raddr;
    logic [31:0]   b_cycles;

    logic [7:0] dm_bytes [256];
    int n_tests = 0;
    int n_fail  = 0;

    mips_dump_ctrl_if #(.DATA_W(DW)) a_if ();
    mips_dump_ctrl_if #(.DATA_W(DW)) b_if ();

    mips_dump_ctrl #(.DATA_W(DW), .NUM_REGS(A_REGS), .DMEM_WORDS(A_MEM), .MAX_CYCLES(100)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .halt_pc_en(a_hpen), .halt_pc(a_hpc),
        .cpu_pc(a_pc), .cpu_run(a_cpu_run), .rf_raddr(a_rf_raddr), .rf_rdata(a_rf_rdata),
        .dm_raddr(a_dm_raddr), .dm_rdata(a_dm_rdata), .dump(a_if), .busy(a_busy),
        .done(a_done), .halt_cause(a_cause), .run_cycles(a_cycles)
    );

    mips_dump_ctrl #(.DATA_W(DW), .NUM_REGS(B_REGS), .DMEM_WORDS(0), .MAX_CYCLES(5)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .halt_pc_en(b_hpen), .halt_pc(b_hpc),
        .cpu_pc(b_pc), .cpu_run(b_cpu_run), .rf_raddr(b_rf_raddr), .rf_rdata(b_rf_rdata),
        .dm_raddr(b_dm_raddr), .dm_rdata(32'd0), .dump(b_if), .busy(b_busy),
        .done(b_done), .halt_cause(b_cause), .run_cycles(b_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rf_val(input logic [7:0] i);
        return 32'hC0DE_0000 ^ ({24'd0, i} * 32'h0001_0003);
    endfunction

    function automatic logic [31:0] mem_word(input logic [7:0] w);
        logic [7:0] a;
        a = {w[5:0], 2'b00};
        return {dm_bytes[a], dm_bytes[a + 8'd1], dm_bytes[a + 8'd2], dm_bytes[a + 8'd3]};
    endfunction

    // CPU, register file and data memory models: one-cycle read latency.
    always @(posedge clk) begin
        if (rst) a_pc <= '0; else if (a_cpu_run) a_pc <= a_pc + 32'd4;
        if (rst) b_pc <= '0; else if (b_cpu_run) b_pc <= b_pc + 32'd4;
        a_rf_rdata <= rf_val(a_rf_raddr);
        b_rf_rdata <= rf_val(b_rf_raddr);
        a_dm_rdata <= mem_word(a_dm_raddr[9:2]);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [41:0] exp_beat(input int b, input logic [31:0] pc);
        logic [7:0] i;
        if (b == 0) return {2'd0, 8'd0, pc};
        if (b <= A_REGS) begin
            i = 8'(b - 1);
            return {2'd1, i, rf_val(i)};
        end
        i = 8'(b - 1 - A_REGS);
        return {2'd2, i, mem_word(i)};
    endfunction

    task automatic check_reset_a(input string t);
        check({t, "_ctl"}, 64'({a_cpu_run, a_if.out_valid, a_busy, a_done, a_cause}), 64'd0);
        check({t, "_cycles"}, 64'(a_cycles), 64'd0);
        check({t, "_data"}, 64'(a_if.out_data), 64'd0);
        check({t, "_kind_idx"}, 64'({a_if.out_kind, a_if.out_index}), 64'd0);
        check({t, "_addr"}, 64'({a_rf_raddr, a_dm_raddr}), 64'd0);
    endtask

    // Counts negedges with cpu_run high; optionally pokes start mid-run.
    task automatic count_run_a(input bit poke, output int n);
        n = 0;
        for (int c = 0; c < 1000; c++) begin
            if (a_cpu_run) n++;
            else if (n > 0) break;
            a_start = poke && (n == 10);
            @(negedge clk);
        end
        a_start = 1'b0;
    endtask

    task automatic dump_a(input logic [31:0] pc, input int stall_beat, input int stall_len,
                          input int abort_beat);
        int b = 0;
        int cyc = 0;
        int last_fire = 0;
        int errs;
        logic v;
        logic prev_v = 1'b0;
        logic [41:0] got, snap;
        a_if.out_ready = 1'b1;
        while (b < A_BEATS && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            v   = a_if.out_valid;
            got = {a_if.out_kind, a_if.out_index, a_if.out_data};
            if (v && !prev_v) begin
                if (b > 0) check($sformatf("gap%0d", b), 64'(cyc - last_fire), 64'd2);
                check($sformatf("beat%0d", b), 64'(got), 64'(exp_beat(b, pc)));
                if (b == 9)  check("reg8_data", 64'(got[31:0]), 64'h0000_0000_C0D6_0018);
                if (b == 36) check("mem3_data", 64'(got[31:0]), 64'h0000_0000_1C1D_1E1F);
                if (b == abort_beat) break;
                if (b == stall_beat) begin
                    snap = got;
                    errs = 0;
                    a_if.out_ready = 1'b0;
                    for (int i = 0; i < stall_len; i++) begin
                        @(negedge clk);
                        cyc++;
                        if (!a_if.out_valid ||
                            {a_if.out_kind, a_if.out_index, a_if.out_data} !== snap) errs++;
                    end
                    check("stall_hold", 64'(errs), 64'd0);
                    a_if.out_ready = 1'b1;
                end
            end
            if (v && a_if.out_ready) begin
                last_fire = cyc + 1;
                b++;
            end
            prev_v = v;
        end
        if (abort_beat < 0) begin
            check("beat_count", 64'(b), 64'(A_BEATS));
            @(negedge clk);
            check("done_state", 64'({a_done, a_busy, a_if.out_valid}), 64'b100);
            repeat (3) @(negedge clk);
            check("done_held", 64'({a_done, a_busy, a_if.out_valid}), 64'b100);
        end
    endtask

    initial begin
        int n, fires, mem_beats;
        for (int k = 0; k < 256; k++) dm_bytes[k] = 8'(8'h10 + k);
        a_if.out_ready = 1'b1;
        b_if.out_ready = 1'b1;

        // Reset asserted together with start: reset wins.
        rst = 1'b1;
        a_start = 1'b1;
        repeat (2) @(negedge clk);
        a_start = 1'b0;
        check_reset_a("por");
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst", 64'({a_busy, a_cpu_run, b_busy}), 64'd0);

        // Run to cycle cap, with a start pulse mid-run that must be ignored.
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        count_run_a(1'b1, n);
        check("cap_run_len", 64'(n), 64'd100);
        check("cap_cause", 64'(a_cause), 64'd0);
        check("cap_cycles", 64'(a_cycles), 64'd100);
        check("cap_busy", 64'({a_busy, a_done}), 64'b10);
        dump_a(32'h0000_018C, -1, 0, -1);

        // Breakpoint at 0x10 from PC 0, with 7 cycles of backpressure on REG 5.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a_hpen = 1'b1;
        a_hpc  = 32'h0000_0010;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        count_run_a(1'b0, n);
        check("bp_run_len", 64'(n), 64'd5);
        check("bp_cause", 64'(a_cause), 64'd1);
        check("bp_cycles", 64'(a_cycles), 64'd5);
        dump_a(32'h0000_0010, 6, 7, -1);

        // Restart from DONE to the cap, then reset while MEM beat 2 is presented.
        a_hpen = 1'b0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        count_run_a(1'b0, n);
        check("rerun_len", 64'(n), 64'd100);
        dump_a(32'h0000_01A0, -1, 0, 35);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_a("abort");
        a_hpen = 1'b1;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        count_run_a(1'b0, n);
        check("post_abort_len", 64'(n), 64'd5);
        dump_a(32'h0000_0010, -1, 0, -1);

        // Instance B: breakpoint and cap coincide on the 5th cycle; no MEM phase.
        b_hpen = 1'b1;
        b_hpc  = 32'h0000_0010;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            if (b_cpu_run) n++;
            else if (n > 0) break;
            @(negedge clk);
        end
        check("tie_run_len", 64'(n), 64'd5);
        check("tie_cause", 64'(b_cause), 64'd1);
        check("tie_cycles", 64'(b_cycles), 64'd5);
        fires = 0;
        mem_beats = 0;
        for (int c = 0; c < 200 && !b_done; c++) begin
            @(negedge clk);
            if (b_if.out_valid && b_if.out_ready) begin
                if (fires == 0)
                    check("tie_pc_beat", 64'({b_if.out_kind, b_if.out_index, b_if.out_data}),
                          64'({2'd0, 8'd0, 32'h0000_0010}));
                if (fires == 4)
                    check("tie_last_beat", 64'({b_if.out_kind, b_if.out_index, b_if.out_data}),
                          64'({2'd1, 8'd3, rf_val(8'd3)}));
                if (b_if.out_kind == KIND_MEM) mem_beats++;
                fires++;
            end
        end
        check("tie_beat_count", 64'(fires), 64'(1 + B_REGS));
        check("tie_mem_beats", 64'(mem_beats), 64'd0);
        check("tie_done", 64'({b_done, b_busy}), 64'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
